// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes, FSM encoding
// and the access legality check.
package mem_access_unit_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WR   = 3'd2,
    S_FIN  = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  // Misaligned halfword/word, reserved width codes, or unsigned store widths.
  function automatic logic access_err(input logic       store,
                                      input logic [2:0] funct3,
                                      input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    case (funct3)
      F3_B, F3_BU: bad = 1'b0;
      F3_H, F3_HU: bad = addr_lo[0];
      F3_W:        bad = |addr_lo;
      default:     bad = 1'b1;
    endcase
    if (store && funct3[2]) bad = 1'b1;
    return bad;
  endfunction

endpackage

// File: rtl/mem_access_unit_lane.sv
// mem_lane_align: byte/halfword lane extraction for loads and lane merge for
// sub-word stores into a full memory word.
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] i_rd_word,
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merge
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_sext;

  always_comb begin
    w_byte = 8'h00;
    case (i_addr_lo)
      2'd0:    w_byte = i_rd_word[7:0];
      2'd1:    w_byte = i_rd_word[15:8];
      2'd2:    w_byte = i_rd_word[23:16];
      default: w_byte = i_rd_word[31:24];
    endcase
    w_half = i_addr_lo[1] ? i_rd_word[31:16] : i_rd_word[15:0];
    w_sext = ~i_funct3[2];
  end

  always_comb begin
    o_load = i_rd_word;
    case (i_funct3[1:0])
      2'b00:   o_load = {{24{w_sext & w_byte[7]}}, w_byte};
      2'b01:   o_load = {{16{w_sext & w_half[15]}}, w_half};
      default: o_load = i_rd_word;
    endcase
  end

  always_comb begin
    o_merge = i_rd_word;
    case (i_funct3[1:0])
      2'b00:   o_merge[{i_addr_lo, 3'b000} +: 8] = i_wdata[7:0];
      2'b01:   o_merge[{i_addr_lo[1], 4'b0000} +: 16] = i_wdata[15:0];
      default: o_merge = i_wdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer between a core and a combinational-read word memory.
// Sub-word stores are done as read-modify-write.
//   state  | meaning
//   IDLE   | waiting for req
//   RD     | memory word read; load result or merged store word captured
//   WR     | mem_WE high, merged word or full word written
//   FIN    | done pulse, no error
//   ERR    | done pulse with err, nothing touched
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req,
  input  logic            store,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] mem_A,
  output logic            mem_WE,
  output logic [XLEN-1:0] mem_WD,
  input  logic [XLEN-1:0] mem_RD
);

  state_t          r_state;
  logic            r_store;
  logic [2:0]      r_f3;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_wdata;
  logic [XLEN-1:0] r_wd;
  logic [XLEN-1:0] r_rdata;
  logic            r_busy;
  logic            r_done;
  logic            r_err;
  logic            r_we;
  logic [XLEN-1:0] w_load;
  logic [XLEN-1:0] w_merge;

  mem_lane_align u_align (
    .i_rd_word (mem_RD),
    .i_addr_lo (r_addr[1:0]),
    .i_funct3  (r_f3),
    .i_wdata   (r_wdata),
    .o_load    (w_load),
    .o_merge   (w_merge)
  );

  // Outputs are registered from the next state so they never glitch on inputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_store <= 1'b0;
      r_f3    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wd    <= '0;
      r_rdata <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_we    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      r_we   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_store <= store;
            r_f3    <= funct3;
            r_addr  <= addr;
            r_wdata <= wdata;
            r_busy  <= 1'b1;
            if (access_err(store, funct3, addr[1:0])) begin
              r_state <= S_ERR;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
            end else if (store && funct3 == F3_W) begin
              r_state <= S_WR;
              r_we    <= 1'b1;
              r_wd    <= wdata;
            end else begin
              r_state <= S_RD;
            end
          end
        end
        S_RD: begin
          if (r_store) begin
            r_wd    <= w_merge;
            r_we    <= 1'b1;
            r_state <= S_WR;
          end else begin
            r_rdata <= w_load;
            r_done  <= 1'b1;
            r_state <= S_FIN;
          end
        end
        S_WR: begin
          r_done  <= 1'b1;
          r_state <= S_FIN;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign err    = r_err;
  assign rdata  = r_rdata;
  assign mem_A  = {r_addr[XLEN-1:2], 2'b00};
  assign mem_WE = r_we;
  assign mem_WD = r_wd;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit against a byte-level reference model
// of RV32I loads/stores, plus directed literal cases.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic [31:0] mem_A;
  logic        mem_WE;
  logic [31:0] mem_WD;
  logic [31:0] mem_RD;

  always #5 clk = ~clk;

  mem_access_unit #(.XLEN(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .store  (store),
    .funct3 (funct3),
    .addr   (addr),
    .wdata  (wdata),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .rdata  (rdata),
    .mem_A  (mem_A),
    .mem_WE (mem_WE),
    .mem_WD (mem_WD),
    .mem_RD (mem_RD)
  );

  logic [31:0] tb_mem [0:63];
  logic        pre_we;
  logic [5:0]  pre_idx;
  logic [31:0] pre_val;

  assign mem_RD = tb_mem[mem_A[7:2]];
  always @(posedge clk) begin
    if (pre_we) tb_mem[pre_idx] <= pre_val;
    else if (mem_WE) tb_mem[mem_A[7:2]] <= mem_WD;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        err;
    logic        we;
    logic [31:0] rdata;
    logic [31:0] wd;
    logic [5:0]  idx;
  } exp_t;

  exp_t        q[$];
  exp_t        me;
  logic [31:0] m_mem [0:63];
  logic [31:0] m_rdata;
  bit          skip;
  int          cyc = 0;
  int          start_cyc = 0;
  int          last_lat = 0;
  int          done_cnt = 0;
  int          we_cnt = 0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (done)   done_cnt++;
      if (mem_WE) we_cnt++;
      if (!skip) begin
        if (q.size() > 0) begin
          me = q.pop_front();
          check("busy", {31'd0, busy}, {31'd0, me.busy});
          check("done", {31'd0, done}, {31'd0, me.done});
          check("err", {31'd0, err}, {31'd0, me.err});
          check("mem_WE", {31'd0, mem_WE}, {31'd0, me.we});
          check("rdata", rdata, me.rdata);
          if (me.we) check("mem_WD", mem_WD, me.wd);
          if (me.done) begin
            check("mem_word", tb_mem[me.idx], m_mem[me.idx]);
            last_lat = cyc - start_cyc + 2;
          end
        end else begin
          check("idle_busy", {31'd0, busy}, 32'd0);
          check("idle_done", {31'd0, done}, 32'd0);
          check("idle_we", {31'd0, mem_WE}, 32'd0);
          check("idle_rdata", rdata, m_rdata);
        end
      end
    end
  end

  task automatic poke(input int i, input logic [31:0] v);
    @(negedge clk);
    pre_we  = 1'b1;
    pre_idx = i[5:0];
    pre_val = v;
    m_mem[i] = v;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Reference: size/sign from the width code, legality from size alignment.
  task automatic access(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input bit hold);
    int          sz;
    int          sh;
    int          n;
    bit          sgn;
    bit          legal;
    bit          bad;
    logic [5:0]  idx;
    logic [31:0] word;
    logic [31:0] mask;
    logic [31:0] val;
    logic [31:0] nw;
    exp_t        e;
    legal = 1'b1;
    sgn   = 1'b0;
    case (f3)
      3'd0: begin sz = 1; sgn = 1'b1; end
      3'd1: begin sz = 2; sgn = 1'b1; end
      3'd2: sz = 4;
      3'd4: sz = 1;
      3'd5: sz = 2;
      default: begin sz = 1; legal = 1'b0; end
    endcase
    if (st && f3 > 3'd2) legal = 1'b0;
    bad  = !legal || ((a % sz) != 0);
    idx  = a[7:2];
    word = m_mem[idx];
    sh   = 8 * int'(a % 4);
    mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
    e = '{busy: 1'b1, done: 1'b0, err: 1'b0, we: 1'b0, rdata: m_rdata, wd: 32'd0, idx: idx};
    @(negedge clk);
    req = 1'b1; store = st; funct3 = f3; addr = a; wdata = wd;
    @(posedge clk);
    start_cyc = cyc + 1;
    if (bad) begin
      e.done = 1'b1; e.err = 1'b1;
      q.push_back(e);
      n = 1;
    end else if (!st) begin
      val = (word >> sh) & mask;
      if (sgn && sz < 4 && val[8*sz-1]) val = val | ~mask;
      q.push_back(e);
      m_rdata = val;
      e.done = 1'b1; e.rdata = val;
      q.push_back(e);
      n = 2;
    end else begin
      nw = (word & ~(mask << sh)) | ((wd & mask) << sh);
      m_mem[idx] = nw;
      n = 2;
      if (sz < 4) begin
        q.push_back(e);
        n = 3;
      end
      e.we = 1'b1; e.wd = nw;
      q.push_back(e);
      e.we = 1'b0; e.done = 1'b1;
      q.push_back(e);
    end
    repeat (n) @(negedge clk);
    if (hold) @(negedge clk);
    req = 1'b0;
  endtask

  int          w0;
  int          d0;
  logic [2:0]  rf3;
  logic [31:0] ra;
  logic [2:0]  legal_f3 [0:4];

  initial begin
    rst = 1'b1; req = 1'b0; store = 1'b0; funct3 = 3'd0; addr = 32'd0; wdata = 32'd0;
    pre_we = 1'b0; pre_idx = 6'd0; pre_val = 32'd0; skip = 1'b1; m_rdata = 32'd0;
    legal_f3[0] = 3'd0; legal_f3[1] = 3'd1; legal_f3[2] = 3'd2; legal_f3[3] = 3'd4; legal_f3[4] = 3'd5;
    #1 rst = 1'b0;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_we", {31'd0, mem_WE}, 32'd0);
    for (int i = 0; i < 64; i++) poke(i, $urandom);
    poke(4, 32'h8081_8283);
    @(negedge clk);
    rst = 1'b1; skip = 1'b0;

    access(1'b0, 3'd2, 32'h10, 32'd0, 1'b0);
    check("lw_rdata", rdata, 32'h8081_8283);
    check("lw_latency", last_lat, 3);
    access(1'b0, 3'd0, 32'h13, 32'd0, 1'b0);
    check("lb_rdata", rdata, 32'hFFFF_FF80);
    access(1'b0, 3'd4, 32'h13, 32'd0, 1'b0);
    check("lbu_rdata", rdata, 32'h0000_0080);

    poke(4, 32'h1122_3344);
    w0 = we_cnt;
    access(1'b1, 3'd0, 32'h11, 32'h0000_00AB, 1'b0);
    check("sb_word", tb_mem[4], 32'h1122_AB44);
    check("sb_we_cycles", we_cnt - w0, 1);
    check("sb_latency", last_lat, 4);

    w0 = we_cnt;
    access(1'b0, 3'd1, 32'h11, 32'd0, 1'b0);
    check("lh_err_latency", last_lat, 2);
    access(1'b1, 3'd2, 32'h12, 32'hDEAD_BEEF, 1'b0);
    check("sw_err_latency", last_lat, 2);
    check("err_no_we", we_cnt - w0, 0);
    check("err_mem_kept", tb_mem[4], 32'h1122_AB44);
    check("err_rdata_kept", rdata, 32'h0000_0080);

    poke(8, 32'hCAFE_F00D);
    d0 = done_cnt;
    @(negedge clk);
    skip = 1'b1;
    req = 1'b1; store = 1'b1; funct3 = 3'd1; addr = 32'h20; wdata = 32'h0000_5555;
    @(posedge clk);
    #2;
    check("rd_busy", {31'd0, busy}, 32'd1);
    rst = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_we", {31'd0, mem_WE}, 32'd0);
    check("abort_rdata", rdata, 32'd0);
    m_rdata = 32'd0;
    req = 1'b0;
    #1;
    rst = 1'b1; skip = 1'b0;
    access(1'b1, 3'd1, 32'h20, 32'h0000_5555, 1'b0);
    check("abort_one_done", done_cnt - d0, 1);
    check("sh_after_rst", tb_mem[8], 32'hCAFE_5555);
    check("sh_latency", last_lat, 4);

    d0 = done_cnt;
    access(1'b0, 3'd2, 32'h10, 32'd0, 1'b1);
    check("held_req_one_done", done_cnt - d0, 1);

    for (int k = 0; k < 400; k++) begin
      rf3 = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : legal_f3[$urandom_range(0, 4)];
      ra  = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) ra[1:0] = 2'b00;
      access(1'($urandom_range(0, 1)), rf3, ra, $urandom, $urandom_range(0, 7) == 0);
    end

    repeat (3) @(negedge clk);
    check("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
